// File: rtl/dmi_pkg.sv
// Shared types, defaults and the address legality check for data_mem_initiator.
package dmi_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StDone
  } dmi_state_e;

  localparam int unsigned DefAddrW    = 18;
  localparam int unsigned DefBaseAddr = 1024;

  typedef struct packed {
    logic        legal;
    logic [29:0] word;
  } dmi_chk_t;

  // Word index relative to base; legal only if aligned, at/above base and inside addr_w bits.
  function automatic dmi_chk_t dmi_check_addr(input logic [31:0] addr, input logic [31:0] base,
                                              input int unsigned addr_w);
    dmi_chk_t    r;
    logic [31:0] off;
    off     = addr - base;
    r.word  = 30'(off >> 2);
    r.legal = (addr[1:0] == 2'b00) && (addr >= base) && ((r.word >> addr_w) == '0);
    return r;
  endfunction

endpackage

// File: rtl/dmi_wait_counter.sv
// Access-window counter: cleared by start, counts while en, flags the final window cycle.
module dmi_wait_counter #(
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic en,
  output logic last
);

  localparam int unsigned CntW = $clog2(ACCESS_CYCLES) + 1;

  logic [CntW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (start) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last = (count_q == CntW'(ACCESS_CYCLES - 1));

endmodule

// File: rtl/data_mem_initiator.sv
// MEM-stage load/store engine driving a fixed-window data memory port.
// Build option: define DMI_WRITE_POST_EN to post legal stores in the background.
module data_mem_initiator
  import dmi_pkg::*;
#(
  parameter int unsigned ADDR_W        = DefAddrW,
  parameter int unsigned BASE_ADDR     = DefBaseAddr,
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_rd,
  input  logic              req_wr,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic [31:0]       rdata,
  output logic              ready,
  output logic              err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

`ifdef DMI_WRITE_POST_EN
  localparam bit PostEn = 1'b1;
`else
  localparam bit PostEn = 1'b0;
`endif

  dmi_state_e        state_q, state_d;
  logic              rd_q, wr_q, posted_q, err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, rdata_q;
  dmi_chk_t          chk;
  logic              req_any, req_legal, req_posted, cnt_last;

  assign chk        = dmi_check_addr(req_addr, 32'(BASE_ADDR), ADDR_W);
  assign req_any    = req_rd | req_wr;
  assign req_legal  = chk.legal & ~(req_rd & req_wr);
  assign req_posted = PostEn & req_wr & req_legal;

  dmi_wait_counter #(
    .ACCESS_CYCLES(ACCESS_CYCLES)
  ) u_wait_counter (
    .clk  (clk),
    .rst  (rst),
    .start(state_q == StIdle),
    .en   (state_q == StAccess),
    .last (cnt_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (req_any) begin
          state_d = req_legal ? StAccess : StDone;
        end
      end
      StAccess: begin
        // A posted store has nobody waiting on it, so it skips the DONE handshake.
        if (cnt_last) begin
          state_d = posted_q ? StIdle : StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ready = 1'b0;
    case (state_q)
      StIdle:   ready = ~req_any | req_posted;
      StAccess: ready = posted_q & ~req_any;
      StDone:   ready = 1'b1;
      default:  ready = 1'b0;
    endcase
    mem_read  = (state_q == StAccess) & rd_q;
    mem_write = (state_q == StAccess) & wr_q;
    err       = (state_q == StDone) & err_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      posted_q <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      if (state_q == StIdle && req_any) begin
        err_q <= ~req_legal;
        if (req_legal) begin
          rd_q     <= req_rd;
          wr_q     <= req_wr;
          posted_q <= req_posted;
          addr_q   <= ADDR_W'(chk.word);
          wdata_q  <= req_wdata;
        end
      end
      if (state_q == StAccess && cnt_last && rd_q) begin
        rdata_q <= mem_rdata;
      end
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_data_mem_initiator.sv
// Directed bench for data_mem_initiator: vector table plus reset, back-to-back and posted-store sequences.
module tb_data_mem_initiator;

  localparam int AC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_rd, req_wr;
  logic [31:0] req_addr, req_wdata;
  logic [31:0] rdata;
  logic        ready, err, mem_read, mem_write;
  logic [17:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [31:0] mem[256];

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        legal;
    logic [17:0] maddr;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[9];

  data_mem_initiator #(
    .ADDR_W       (18),
    .BASE_ADDR    (1024),
    .ACCESS_CYCLES(AC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_rd   (req_rd),
    .req_wr   (req_wr),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rdata    (rdata),
    .ready    (ready),
    .err      (err),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: combinational read, write on each edge with mem_write high.
  assign mem_rdata = mem[mem_addr[7:0]];
  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 256; k++) mem[k] <= 32'h0;
      mem[0]   <= 32'hCAFEF00D;
      mem[4]   <= 32'h55555555;
      mem[7]   <= 32'h77777777;
      mem[255] <= 32'h12345678;
    end else if (mem_write) begin
      mem[mem_addr[7:0]] <= mem_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata);
    req_rd    = rd;
    req_wr    = wr;
    req_addr  = addr;
    req_wdata = wdata;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    bit   posted;
    v      = vecs[i];
    posted = 1'b0;
`ifdef DMI_WRITE_POST_EN
    posted = v.legal && v.wr;
`endif
    @(posedge clk); #1;
    drive(v.rd, v.wr, v.addr, v.wdata);
    @(negedge clk);
    chk($sformatf("v%0d_c0_ready", i), 32'(ready), 32'(posted));
    chk($sformatf("v%0d_c0_strobes", i), 32'({mem_read, mem_write}), 32'h0);
    if (posted) begin
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 32'h0, 32'h0);
    end
    if (v.legal) begin
      for (int c = 1; c <= AC; c++) begin
        @(negedge clk);
        chk($sformatf("v%0d_c%0d_strobes", i, c), 32'({mem_read, mem_write}), 32'({v.rd, v.wr}));
        chk($sformatf("v%0d_c%0d_addr", i, c), 32'(mem_addr), 32'(v.maddr));
        chk($sformatf("v%0d_c%0d_ready", i, c), 32'(ready), 32'(posted));
      end
      @(negedge clk);
      chk($sformatf("v%0d_done_ready", i), 32'(ready), 32'h1);
      chk($sformatf("v%0d_done_strobes", i), 32'({mem_read, mem_write}), 32'h0);
      chk($sformatf("v%0d_done_err", i), 32'(err), 32'h0);
      chk($sformatf("v%0d_done_rdata", i), rdata, v.rdata);
    end else begin
      @(negedge clk);
      chk($sformatf("v%0d_c1_ready", i), 32'(ready), 32'h1);
      chk($sformatf("v%0d_c1_err", i), 32'(err), 32'h1);
      chk($sformatf("v%0d_c1_strobes", i), 32'({mem_read, mem_write}), 32'h0);
      chk($sformatf("v%0d_c1_rdata", i), rdata, v.rdata);
    end
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk($sformatf("v%0d_idle_err", i), 32'(err), 32'h0);
    chk($sformatf("v%0d_idle_ready", i), 32'(ready), 32'h1);
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 32'h0000_0410, 32'h0,          1'b1, 18'd4,       32'h55555555};
    vecs[1] = '{1'b0, 1'b1, 32'h0000_0418, 32'hAAAAAAAA,   1'b1, 18'd6,       32'h55555555};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0418, 32'h0,          1'b1, 18'd6,       32'hAAAAAAAA};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_0411, 32'h0,          1'b0, 18'd0,       32'hAAAAAAAA};
    vecs[4] = '{1'b0, 1'b1, 32'h0000_03FC, 32'h11111111,   1'b0, 18'd0,       32'hAAAAAAAA};
    vecs[5] = '{1'b1, 1'b1, 32'h0000_0410, 32'h22222222,   1'b0, 18'd0,       32'hAAAAAAAA};
    vecs[6] = '{1'b1, 1'b0, 32'h0000_0400, 32'h0,          1'b1, 18'd0,       32'hCAFEF00D};
    vecs[7] = '{1'b1, 1'b0, 32'h0010_03FC, 32'h0,          1'b1, 18'h3FFFF,   32'h12345678};
    vecs[8] = '{1'b1, 1'b0, 32'h0010_0400, 32'h0,          1'b0, 18'd0,       32'h12345678};

    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(ready), 32'h1);
    chk("rst_outputs", {rdata[15:0], 7'(mem_addr), err, mem_read, mem_write, 6'(mem_wdata)},
        32'h0);

    // Reset during cycle 1 of a load aborts it without touching rdata.
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 32'h0000_041C, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("rstmid_c1_read", 32'(mem_read), 32'h1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_strobes", 32'({mem_read, mem_write, err}), 32'h0);
    chk("rstmid_addr", 32'(mem_addr), 32'h0);
    chk("rstmid_rdata", rdata, 32'h0);
    @(negedge clk);
    chk("rstmid_rdata_hold", rdata, 32'h0);
    chk("rstmid_ready", 32'(ready), 32'h1);

    for (int i = 0; i < 9; i++) run_vec(i);

    // Request held through DONE is a new instruction; strobes drop for the DONE cycle.
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 32'h0000_0410, 32'h0);
    repeat (AC + 1) @(negedge clk);
    @(negedge clk);
    chk("b2b_done_ready", 32'(ready), 32'h1);
    chk("b2b_done_read", 32'(mem_read), 32'h0);
    @(negedge clk);
    chk("b2b_idle_ready", 32'(ready), 32'h0);
    chk("b2b_idle_read", 32'(mem_read), 32'h0);
    @(negedge clk);
    chk("b2b_second_read", 32'(mem_read), 32'h1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (AC + 2) @(negedge clk);
    chk("b2b_settled_ready", 32'(ready), 32'h1);

`ifdef DMI_WRITE_POST_EN
    // Posted store followed immediately by a load of the same word.
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 32'h0000_0424, 32'h24242424);
    @(negedge clk);
    chk("post_c0_ready", 32'(ready), 32'h1);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 32'h0000_0424, 32'h0);
    for (int c = 1; c <= AC; c++) begin
      @(negedge clk);
      chk($sformatf("post_c%0d_ready", c), 32'(ready), 32'h0);
      chk($sformatf("post_c%0d_write", c), 32'(mem_write), 32'h1);
      chk($sformatf("post_c%0d_addr", c), 32'(mem_addr), 32'd9);
    end
    @(negedge clk);
    chk("post_idle_ready", 32'(ready), 32'h0);
    chk("post_idle_strobes", 32'({mem_read, mem_write}), 32'h0);
    for (int c = 1; c <= AC; c++) begin
      @(negedge clk);
      chk($sformatf("post_ld_c%0d_read", c), 32'(mem_read), 32'h1);
    end
    @(negedge clk);
    chk("post_ld_ready", 32'(ready), 32'h1);
    chk("post_ld_rdata", rdata, 32'h24242424);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
`endif

    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
